// File: rtl/uart_pkg.sv
// Constants and types shared by the UART transmit path and its arbiter.
package uart_pkg;

    localparam int unsigned CLK_HZ   = 50250000;
    localparam int unsigned BAUD     = 115200;
    localparam int unsigned BAUD_DIV = CLK_HZ / BAUD;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } arb_state_e;

    // Counter width able to hold max_val, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte streams plus the uart_tx data handshake of the arbiter.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);

    logic [NUM_REQ-1:0]   req_valid_i;
    logic [NUM_REQ*8-1:0] req_data_i;
    logic [NUM_REQ-1:0]   req_last_i;
    logic [NUM_REQ-1:0]   req_ready_o;
    logic [NUM_REQ-1:0]   grant_o;
    logic                 busy_o;
    logic                 uart_val_o;
    logic [7:0]           uart_data_o;
    logic                 uart_rdy_i;

    // Arbiter side.
    modport slave (
        input  req_valid_i, req_data_i, req_last_i, uart_rdy_i,
        output req_ready_o, grant_o, busy_o, uart_val_o, uart_data_o
    );

    // Requester / uart_tx side.
    modport master (
        output req_valid_i, req_data_i, req_last_i, uart_rdy_i,
        input  req_ready_o, grant_o, busy_o, uart_val_o, uart_data_o
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, cyclically.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic          any_o
);

    logic          found;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sum = {1'b0, ptr_i} + (PW+1)'(i);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one uart_tx among NUM_REQ byte streams.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned MAX_BURST    = 64,
    parameter int unsigned IDLE_TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_arbiter_if.slave bus
);

    localparam int unsigned PTR_W     = $clog2(NUM_REQ);
    localparam int unsigned BCNT_W    = cnt_width(MAX_BURST);
    localparam int unsigned ICNT_W    = cnt_width(IDLE_TIMEOUT);
    localparam int unsigned BURST_END = (MAX_BURST == 0) ? 0 : MAX_BURST - 1;
    localparam int unsigned IDLE_END  = (IDLE_TIMEOUT == 0) ? 0 : IDLE_TIMEOUT - 1;
    localparam bit          BURST_EN  = (MAX_BURST != 0);
    localparam bit          TMO_EN    = (IDLE_TIMEOUT != 0);

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic                busy_q, busy_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    gidx_q, gidx_d;
    logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [ICNT_W-1:0]   idle_cnt_q, idle_cnt_d;

    logic [NUM_REQ-1:0]  pick_gnt;
    logic                pick_any;
    logic [PTR_W-1:0]    pick_idx;
    logic [PTR_W-1:0]    ptr_nxt;
    logic                sel_valid, sel_last;
    logic [7:0]          sel_data;
    logic                xfer, starved, eop, tmo;
    logic [NUM_REQ-1:0]  ready_c;
    logic                val_c;
    logic [7:0]          data_c;

    rr_pick #(
        .N  (NUM_REQ),
        .PW (PTR_W)
    ) u_pick (
        .req_i (bus.req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .any_o (pick_any)
    );

    // One-hot pick to index.
    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) begin
                pick_idx = PTR_W'(i);
            end
        end
    end

    assign sel_valid = bus.req_valid_i[gidx_q];
    assign sel_last  = bus.req_last_i[gidx_q];
    assign sel_data  = bus.req_data_i[{gidx_q, 3'b000} +: 8];
    assign ptr_nxt   = (gidx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_q + PTR_W'(1);

    // Waiting on a busy UART is not starvation, so only ready-but-empty cycles count.
    assign xfer    = (state_q == ST_SEND) && bus.uart_rdy_i && sel_valid;
    assign starved = (state_q == ST_SEND) && bus.uart_rdy_i && !sel_valid;
    assign eop     = xfer && (sel_last || (BURST_EN && (byte_cnt_q == BCNT_W'(BURST_END))));
    assign tmo     = starved && TMO_EN && (idle_cnt_q == ICNT_W'(IDLE_END));

    // Ready and valid follow uart_rdy_i so nothing is offered in uart_tx's first idle cycle.
    always_comb begin
        ready_c = '0;
        val_c   = 1'b0;
        data_c  = '0;
        if (state_q == ST_SEND) begin
            ready_c[gidx_q] = bus.uart_rdy_i;
            val_c           = bus.uart_rdy_i && sel_valid;
            data_c          = sel_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        busy_d     = busy_q;
        ptr_d      = ptr_q;
        gidx_d     = gidx_q;
        byte_cnt_d = byte_cnt_q;
        idle_cnt_d = idle_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d    = ST_SEND;
                    grant_d    = pick_gnt;
                    busy_d     = 1'b1;
                    gidx_d     = pick_idx;
                    byte_cnt_d = '0;
                    idle_cnt_d = '0;
                end
            end
            ST_SEND: begin
                if (xfer) begin
                    byte_cnt_d = byte_cnt_q + BCNT_W'(1);
                    idle_cnt_d = '0;
                end else if (starved) begin
                    idle_cnt_d = idle_cnt_q + ICNT_W'(1);
                end
                if (eop || tmo) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    ptr_d   = ptr_nxt;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            ptr_q      <= '0;
            gidx_q     <= '0;
            byte_cnt_q <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            ptr_q      <= ptr_d;
            gidx_q     <= gidx_d;
            byte_cnt_q <= byte_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign bus.grant_o     = grant_q;
    assign bus.busy_o      = busy_q;
    assign bus.req_ready_o = ready_c;
    assign bus.uart_val_o  = val_c;
    assign bus.uart_data_o = data_c;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a uart_tx ready model and byte scoreboard.
module tb_uart_tx_arbiter;

    localparam int unsigned NR       = 4;
    localparam int unsigned UART_BSY = 12;

    logic clk;
    logic rst_n;
    logic hold;
    logic urdy_q;
    int   ucnt;
    int   total;
    int   bad;

    logic [8:0]  rq [NR][$];
    logic [11:0] exp_q [$];

    uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ      (NR),
        .MAX_BURST    (4),
        .IDLE_TIMEOUT (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // uart_tx ready model: registered, low while shifting and in the first idle cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ucnt   <= 0;
            urdy_q <= 1'b1;
        end else if (bus.uart_val_o && bus.uart_rdy_i) begin
            ucnt   <= UART_BSY;
            urdy_q <= 1'b0;
        end else if (ucnt != 0) begin
            ucnt   <= ucnt - 1;
            urdy_q <= 1'b0;
        end else begin
            urdy_q <= 1'b1;
        end
    end

    assign bus.uart_rdy_i = urdy_q & ~hold;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic refresh();
        logic [NR-1:0]   v;
        logic [NR-1:0]   l;
        logic [NR*8-1:0] d;
        v = '0;
        l = '0;
        d = '0;
        for (int k = 0; k < NR; k++) begin
            if (rq[k].size() != 0) begin
                v[k]         = 1'b1;
                l[k]         = rq[k][0][8];
                d[k*8 +: 8]  = rq[k][0][7:0];
            end
        end
        bus.req_valid_i = v;
        bus.req_last_i  = l;
        bus.req_data_i  = d;
    endtask

    // Requesters pop a byte whenever it was accepted at the preceding edge.
    task automatic driver();
        logic [NR-1:0] fire;
        forever begin
            @(negedge clk);
            fire = bus.req_ready_o & bus.req_valid_i;
            @(posedge clk);
            #1;
            if (rst_n) begin
                for (int k = 0; k < NR; k++) begin
                    if (fire[k]) void'(rq[k].pop_front());
                end
            end
            refresh();
        end
    endtask

    // Accepted bytes against the scoreboard, plus per-cycle grant sanity.
    task automatic monitor();
        logic        cand;
        logic [11:0] got;
        logic [11:0] want;
        logic [3:0]  prev;
        prev = '0;
        forever begin
            @(negedge clk);
            cand = bus.uart_val_o && bus.uart_rdy_i;
            got  = {bus.grant_o, bus.uart_data_o};
            chk("grant_onehot0", 32'($onehot0(bus.grant_o)), 32'd1);
            chk("grant_gap", 32'(prev != 0 && bus.grant_o != 0 && bus.grant_o != prev), 32'd0);
            prev = bus.grant_o;
            @(posedge clk);
            if (cand && rst_n) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", 32'(got), 32'hFFFFFFFF);
                end else begin
                    want = exp_q.pop_front();
                    chk("byte", 32'(got), 32'(want));
                end
            end
        end
    endtask

    task automatic push(input int k, input logic [7:0] d, input logic last);
        rq[k].push_back({last, d});
        exp_q.push_back({4'(1 << k), d});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(input logic [3:0] g, input string tag);
        int n;
        n = 0;
        while (bus.grant_o !== g && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(bus.grant_o), 32'(g));
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((bus.busy_o !== 1'b0 || exp_q.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, 32'(bus.busy_o), 32'd0);
        chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        int starved;
        total = 0;
        bad   = 0;
        hold  = 1'b0;
        rst_n = 1'b0;
        bus.req_valid_i = '0;
        bus.req_last_i  = '0;
        bus.req_data_i  = '0;
        #2;
        chk("rst_grant", 32'(bus.grant_o), 32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_ready", 32'(bus.req_ready_o), 32'd0);
        chk("rst_val", 32'(bus.uart_val_o), 32'd0);
        chk("rst_ptr", 32'(dut.ptr_q), 32'd0);
        fork
            driver();
            monitor();
        join_none
        do_reset();

        // Single requester, three-byte packet.
        push(0, 8'h48, 1'b0);
        push(0, 8'h69, 1'b0);
        push(0, 8'h0A, 1'b1);
        @(negedge clk);
        chk("single_latency", 32'(bus.grant_o), 32'd0);
        @(negedge clk);
        chk("single_grant", 32'(bus.grant_o), 32'b0001);
        wait_idle("single");
        chk("single_grant_end", 32'(bus.grant_o), 32'd0);
        chk("single_ptr", 32'(dut.ptr_q), 32'd1);

        // Fairness between req0 and req2.
        do_reset();
        push(0, 8'hA1, 1'b0);
        push(0, 8'hA2, 1'b1);
        push(2, 8'hB1, 1'b0);
        push(2, 8'hB2, 1'b1);
        push(0, 8'hC1, 1'b0);
        push(0, 8'hC2, 1'b1);
        exp_q.delete();
        exp_q.push_back({4'b0001, 8'hA1});
        exp_q.push_back({4'b0001, 8'hA2});
        exp_q.push_back({4'b0100, 8'hB1});
        exp_q.push_back({4'b0100, 8'hB2});
        exp_q.push_back({4'b0001, 8'hC1});
        exp_q.push_back({4'b0001, 8'hC2});
        wait_idle("fair");
        chk("fair_ptr", 32'(dut.ptr_q), 32'd1);

        // Burst limit of 4 with req3 pending.
        do_reset();
        for (int i = 0; i < 6; i++) rq[1].push_back({1'b0, 8'(8'h10 + i)});
        rq[3].push_back({1'b1, 8'h33});
        for (int i = 0; i < 4; i++) exp_q.push_back({4'b0010, 8'(8'h10 + i)});
        exp_q.push_back({4'b1000, 8'h33});
        exp_q.push_back({4'b0010, 8'h14});
        exp_q.push_back({4'b0010, 8'h15});
        wait_idle("burst");
        chk("burst_ptr", 32'(dut.ptr_q), 32'd2);

        // Idle timeout of 16 starved cycles.
        do_reset();
        push(2, 8'h55, 1'b0);
        wait_grant(4'b0100, "tmo_grant");
        starved = 0;
        n = 0;
        while (bus.grant_o != 0 && n < 300) begin
            if (bus.uart_rdy_i && !bus.req_valid_i[2]) starved++;
            @(negedge clk);
            n++;
        end
        chk("tmo_released", 32'(bus.grant_o), 32'd0);
        chk("tmo_starved", 32'(starved), 32'd16);
        chk("tmo_ptr", 32'(dut.ptr_q), 32'd3);
        wait_idle("tmo");

        // Back-pressure from uart_tx for 100 cycles.
        do_reset();
        hold = 1'b1;
        push(1, 8'h77, 1'b1);
        wait_grant(4'b0010, "bp_grant");
        for (int i = 0; i < 100; i++) begin
            chk("bp_ready", 32'(bus.req_ready_o), 32'd0);
            chk("bp_val", 32'(bus.uart_val_o), 32'd0);
            chk("bp_idle_cnt", 32'(dut.idle_cnt_q), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        hold = 1'b0;
        #1;
        chk("bp_first_val", 32'(bus.uart_val_o), 32'd1);
        chk("bp_first_data", 32'(bus.uart_data_o), 32'h77);
        wait_idle("bp");

        // Reset during req0's second byte.
        do_reset();
        push(0, 8'hD1, 1'b0);
        rq[0].push_back({1'b0, 8'hD2});
        rq[0].push_back({1'b1, 8'hD3});
        n = 0;
        while (!(bus.uart_val_o && bus.uart_data_o == 8'hD2) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("mid_offered", 32'(bus.uart_data_o), 32'hD2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_grant", 32'(bus.grant_o), 32'd0);
        chk("mid_busy", 32'(bus.busy_o), 32'd0);
        chk("mid_ready", 32'(bus.req_ready_o), 32'd0);
        chk("mid_val", 32'(bus.uart_val_o), 32'd0);
        for (int k = 0; k < NR; k++) rq[k].delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("mid_ptr", 32'(dut.ptr_q), 32'd0);
        push(1, 8'h21, 1'b1);
        push(3, 8'h41, 1'b1);
        wait_idle("mid");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx byte transmitter among NUM_REQ independent byte-stream requesters.
- Arbitration is round-robin at packet granularity: a grant is held until the requester's last byte, a burst limit, or an idle timeout.
- Sits between the requester logic (e.g. debug print, status reporter) and uart_tx.
- Drives uart_tx's data valid and data inputs, and observes its registered ready output.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 64, maximum bytes per grant before a forced release; 0 = unlimited.
- IDLE_TIMEOUT, 1024, consecutive starved cycles before a forced release; 0 = disabled.

Ports:
- clk  in  1  system clock (PLL output, same domain as uart_tx).
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid_i  in  NUM_REQ  per-requester byte valid.
- req_data_i  in  NUM_REQ*8  per-requester byte; requester k occupies bits [8k+7:8k].
- req_last_i  in  NUM_REQ  marks the final byte of a packet; qualified by valid.
- req_ready_o  out  NUM_REQ  per-requester byte accept.
- grant_o  out  NUM_REQ  one-hot current owner, registered; all-zero when idle.
- busy_o  out  1  high while any grant is held.
- uart_val_o  out  1  to uart_tx data valid.
- uart_data_o  out  8  to uart_tx data input.
- uart_rdy_i  in  1  from uart_tx ready; registered there, high only while uart_tx is idle.

Behaviour:
- Reset (async, immediate): state IDLE, grant_o=0, busy_o=0, rr pointer=0, byte_cnt=0, idle_cnt=0. req_ready_o and uart_val_o are 0 because they are decoded from IDLE.
- Reset mid-packet: the partial packet is abandoned. No byte is replayed.
- States: IDLE, SEND.
- IDLE:
  - If any req_valid_i bit is set, pick the first set bit scanning cyclically from the rr pointer.
  - Register grant_o as that one-hot value, set busy_o, clear both counters, go to SEND.
  - Latency from valid to grant: 1 clk.
- SEND, with g = granted index:
  - req_ready_o[g] = uart_rdy_i, combinational. All other ready bits are 0.
  - uart_val_o = uart_rdy_i && req_valid_i[g]. uart_data_o = req_data_i[g], both combinational.
  - A transfer is uart_val_o=1. uart_tx accepts that same edge, and uart_rdy_i is guaranteed 0 the next cycle.
  - uart_val_o is never asserted while uart_rdy_i=0. This prevents acceptance in uart_tx's first idle cycle, when its ready output is still low.
  - On a transfer: byte_cnt+1 and idle_cnt cleared.
  - A transfer ends the packet when req_last_i[g]=1, or when MAX_BURST!=0 and byte_cnt==MAX_BURST-1.
  - idle_cnt increments only on cycles with uart_rdy_i=1 and req_valid_i[g]=0. It holds while uart_rdy_i=0, because waiting on the UART is not starvation.
  - Timeout: IDLE_TIMEOUT!=0 and idle_cnt reaches IDLE_TIMEOUT-1 while still starved.
  - Release (end-of-packet or timeout):
    - At that edge: rr pointer = (g+1) mod NUM_REQ, grant_o=0, busy_o=0, next state IDLE.
    - No arbitration occurs in the release cycle, so there is a minimum 1 idle cycle between grants.
- Simultaneous events:
  - last and burst limit on the same byte: a single release.
  - Timeout cannot coincide with a transfer, since idle_cnt is cleared on a transfer.
- A forced release (burst or timeout) does not discard requester state. The requester re-arbitrates and continues its stream.
- Width rules:
  - byte_cnt is clog2(MAX_BURST+1) bits, minimum 1.
  - idle_cnt is clog2(IDLE_TIMEOUT+1) bits, minimum 1.
  - The rr pointer is clog2(NUM_REQ) bits, and its wrap uses explicit compare to NUM_REQ-1.

Decomposition:
- Package uart_pkg:
  - CLK_HZ = 50250000, BAUD = 115200, BAUD_DIV, shared with uart_tx.
  - Arbiter state enum {ST_IDLE, ST_SEND}.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and any-request flag.
  - Reused by future shared-resource controllers.

Test Plan:
- Single requester: req0 streams 0x48,0x69,0x0A with last on 0x0A, into a real uart_tx.
  -> 3 single-cycle uart_val_o pulses with data in that order; grant_o=0001 throughout.
  -> Then IDLE, grant_o=0, rr pointer=1.
- Fairness: req0 and req2 valid from reset, 2-byte packets each, req0 re-requests after its packet.
  -> Grant sequence 0001, 0100, 0001; no grant overlap; at least 1 idle cycle between grants.
- Burst limit: MAX_BURST=4, req1 streams 6 bytes 0x10..0x15 with no last, req3 pending.
  -> Release after 0x13; req3 granted next; req1 later resumes with 0x14.
- Timeout: IDLE_TIMEOUT=16, req2 sends 0x55 without last, then drops valid.
  -> After uart_rdy_i returns high, exactly 16 starved cycles elapse before grant_o=0.
  -> rr pointer=3; no extra uart_val_o.
- Back-pressure: force uart_rdy_i=0 for 100 cycles while req1 is granted and valid.
  -> req_ready_o=0 and uart_val_o=0 for all 100 cycles; idle_cnt stays 0.
  -> First byte is issued on the cycle uart_rdy_i rises.
- Reset mid-packet: assert rst_n=0 during req0's second byte.
  -> grant_o, busy_o, req_ready_o and uart_val_o are 0 within the same cycle.
  -> After release, arbitration restarts from pointer 0.
